apb_cmd_master: RTL

- APB master bridge that sits directly upstream of the APB RAM slave and drives PSEL/PENABLE/PWRITE/PADDR/PWDATA into it.
- Accepts single read/write commands from an internal requester over a valid/ready interface.
- Sequences each command through the APB SETUP and ACCESS phases, then returns read data and a status over a valid/ready response interface.
- Adds address-range checking and a PREADY wait timeout, so a bad address or a hung slave never stalls the requester.

---
 rtl/apb_master_pkg.sv | 22 ++
 rtl/apb_timeout_ctr.sv | 35 +++
 rtl/apb_cmd_master.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and default sizing for the APB command master.
// The FSM state encoding and the timeout counter width helper live here.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_t;

  localparam int AW_DEF          = 8;
  localparam int DW_DEF          = 8;
  localparam int MEM_DEPTH_DEF   = 32;
  localparam int TIMEOUT_CYC_DEF = 16;

  // Counter needs to hold 0..limit; keep at least one bit when disabled.
  function automatic int ctr_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_timeout_ctr.sv
// Counts PREADY-low ACCESS cycles.
// expired flags the wait cycle whose count would reach the limit.
module apb_timeout_ctr
  import apb_master_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  localparam int CW = ctr_width(TIMEOUT_CYC)
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          clear,
  input  logic          enable,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  logic [CW-1:0] cnt_q;

  // A zero limit never expires, which disables the timeout.
  assign expired = enable
                && (limit != '0)
                && (cnt_q == limit - 1'b1);

  // Wait-cycle counter, cleared when a new transfer starts.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// APB master bridge: single commands in, APB SETUP/ACCESS out,
// registered response back, with range check and PREADY timeout.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int AW          = AW_DEF,
  parameter int DW          = DW_DEF,
  parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY
);

  localparam int CW = ctr_width(TIMEOUT_CYC);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);
  localparam logic [AW:0] DEPTH = (AW + 1)'(MEM_DEPTH);

  apb_state_t state_q, state_d;

  logic          psel_d, penable_d, pwrite_d;
  logic [AW-1:0] paddr_d;
  logic [DW-1:0] pwdata_d;
  logic          rsp_valid_d, rsp_err_d;
  logic [DW-1:0] rsp_rdata_d;
  logic          ctr_clear, ctr_en, ctr_expired;
  logic          addr_bad;

  assign cmd_ready = (state_q == IDLE);
  assign addr_bad  = ({1'b0, cmd_addr} >= DEPTH);

  apb_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .PCLK   (PCLK),
    .PRESET (PRESET),
    .clear  (ctr_clear),
    .enable (ctr_en),
    .limit  (LIMIT),
    .expired(ctr_expired)
  );

  // Next state and next register values; everything holds by default.
  always_comb begin
    state_d     = state_q;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    rsp_valid_d = rsp_valid;
    rsp_err_d   = rsp_err;
    rsp_rdata_d = rsp_rdata;
    ctr_clear   = 1'b0;
    ctr_en      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          if (addr_bad) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            ctr_clear = 1'b1;
          end
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          state_d     = RESP;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = PWRITE ? '0 : PRDATA;
        end else begin
          ctr_en = 1'b1;
          if (ctr_expired) begin
            state_d     = RESP;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and all bus/response outputs are registered.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_err   <= rsp_err_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

endmodule
